// File: rtl/spi_sram_pkg.sv
// Shared definitions for the SPI serial-SRAM responder: opcodes, FSM states
// and bit-counter width.
package spi_sram_pkg;

   localparam logic [7:0] CMD_READ  = 8'h03;
   localparam logic [7:0] CMD_WRITE = 8'h02;

   // Wide enough to count the 24 address bits.
   localparam int BIT_CNT_W = 5;

   typedef enum logic [2:0] {
      IDLE,
      CMD,
      ADDR,
      RD_DATA,
      WR_DATA,
      IGNORE
   } state_t;

endpackage

// File: rtl/spi_sram_responder_sync_edge.sv
// Two-flop synchronizer with a third flop for single-clk rise/fall pulses.
module spi_sync_edge #(
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic reset,
   input  logic din,
   output logic rise,
   output logic fall
);

   logic [2:0] pipe_reg;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pipe_reg <= {3{RST_VAL}};
      end else begin
         pipe_reg <= {pipe_reg[1:0], din};
      end
   end

   assign rise = pipe_reg[1] & ~pipe_reg[2];
   assign fall = ~pipe_reg[1] & pipe_reg[2];

endmodule

// File: rtl/spi_sram_responder.sv
// Mode-0 SPI slave emulating a 23LC-style serial SRAM backed by an inline
// byte array; all SPI inputs are oversampled in the clk domain.
module spi_sram_responder #(
   parameter int         ADDR_W    = 8,
   parameter logic [7:0] CMD_READ  = 8'h03,
   parameter logic [7:0] CMD_WRITE = 8'h02
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              sck,
   input  logic              cs_n,
   input  logic              mosi,
   output logic              miso,
   output logic              active,
   output logic              wr_stb,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [7:0]        wr_data
);
   import spi_sram_pkg::*;

   logic                 sck_rise;
   logic                 sck_fall;
   logic [1:0]           cs_sync_reg;
   logic [1:0]           mosi_sync_reg;
   logic                 cs_low;
   logic                 mosi_s;

   state_t               state_reg;
   logic [BIT_CNT_W-1:0] bit_cnt_reg;
   logic [7:0]           shreg_reg;
   logic [ADDR_W-1:0]    addr_reg;
   logic                 rd_cmd_reg;
   logic [1:0]           load_pipe_reg;
   logic [7:0]           rd_data_reg;
   logic [7:0]           byte_in;
   logic                 byte_done;

   logic [7:0] mem [0:(2**ADDR_W)-1];

   spi_sync_edge #(.RST_VAL(1'b0)) u_sck_sync (
      .clk   (clk),
      .reset (reset),
      .din   (sck),
      .rise  (sck_rise),
      .fall  (sck_fall)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cs_sync_reg   <= 2'b11;
         mosi_sync_reg <= 2'b00;
      end else begin
         cs_sync_reg   <= {cs_sync_reg[0], cs_n};
         mosi_sync_reg <= {mosi_sync_reg[0], mosi};
      end
   end

   assign cs_low    = ~cs_sync_reg[1];
   assign mosi_s    = mosi_sync_reg[1];
   assign byte_in   = {shreg_reg[6:0], mosi_s};
   assign byte_done = (bit_cnt_reg == BIT_CNT_W'(7));

   // Registered-read array; the write port is fed from the committed-byte registers.
   always_ff @(posedge clk) begin
      if (wr_stb) begin
         mem[wr_addr] <= wr_data;
      end
      rd_data_reg <= mem[addr_reg];
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg     <= IDLE;
         bit_cnt_reg   <= '0;
         shreg_reg     <= '0;
         addr_reg      <= '0;
         rd_cmd_reg    <= 1'b0;
         load_pipe_reg <= '0;
         miso          <= 1'b0;
         active        <= 1'b0;
         wr_stb        <= 1'b0;
         wr_addr       <= '0;
         wr_data       <= '0;
      end else begin
         wr_stb        <= 1'b0;
         // Address settles one clk, array read takes one more, then the load.
         load_pipe_reg <= {load_pipe_reg[0], 1'b0};
         if (load_pipe_reg[1]) begin
            shreg_reg <= rd_data_reg;
         end

         if (state_reg != IDLE && !cs_low) begin
            state_reg     <= IDLE;
            active        <= 1'b0;
            miso          <= 1'b0;
            bit_cnt_reg   <= '0;
            load_pipe_reg <= '0;
         end else begin
            case (state_reg)
               IDLE: begin
                  miso <= 1'b0;
                  if (cs_low) begin
                     state_reg   <= CMD;
                     active      <= 1'b1;
                     bit_cnt_reg <= '0;
                  end
               end
               CMD: begin
                  if (sck_rise) begin
                     shreg_reg <= byte_in;
                     if (byte_done) begin
                        bit_cnt_reg <= '0;
                        rd_cmd_reg  <= (byte_in == CMD_READ);
                        if (byte_in == CMD_READ || byte_in == CMD_WRITE) begin
                           state_reg <= ADDR;
                        end else begin
                           state_reg <= IGNORE;
                        end
                     end else begin
                        bit_cnt_reg <= bit_cnt_reg + 1'b1;
                     end
                  end
               end
               ADDR: begin
                  // Shifting into an ADDR_W-bit register drops the unused upper bits.
                  if (sck_rise) begin
                     addr_reg <= {addr_reg[ADDR_W-2:0], mosi_s};
                     if (bit_cnt_reg == BIT_CNT_W'(23)) begin
                        bit_cnt_reg <= '0;
                        if (rd_cmd_reg) begin
                           state_reg        <= RD_DATA;
                           load_pipe_reg[0] <= 1'b1;
                        end else begin
                           state_reg <= WR_DATA;
                        end
                     end else begin
                        bit_cnt_reg <= bit_cnt_reg + 1'b1;
                     end
                  end
               end
               RD_DATA: begin
                  if (sck_fall) begin
                     miso      <= shreg_reg[7];
                     shreg_reg <= {shreg_reg[6:0], 1'b0};
                     if (byte_done) begin
                        bit_cnt_reg      <= '0;
                        addr_reg         <= addr_reg + 1'b1;
                        load_pipe_reg[0] <= 1'b1;
                     end else begin
                        bit_cnt_reg <= bit_cnt_reg + 1'b1;
                     end
                  end
               end
               WR_DATA: begin
                  if (sck_rise) begin
                     shreg_reg <= byte_in;
                     if (byte_done) begin
                        wr_stb      <= 1'b1;
                        wr_addr     <= addr_reg;
                        wr_data     <= byte_in;
                        addr_reg    <= addr_reg + 1'b1;
                        bit_cnt_reg <= '0;
                     end else begin
                        bit_cnt_reg <= bit_cnt_reg + 1'b1;
                     end
                  end
               end
               IGNORE: begin
                  miso <= 1'b0;
               end
               default: begin
                  state_reg <= IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_spi_sram_responder.sv
// Directed bench for spi_sram_responder with write/read scoreboards and a
// bench-side memory model.
module tb_spi_sram_responder;

   localparam int HALF = 5;

   logic       clk = 1'b0;
   logic       reset;
   logic       sck;
   logic       cs_n;
   logic       mosi;
   logic       miso;
   logic       active;
   logic       wr_stb;
   logic [7:0] wr_addr;
   logic [7:0] wr_data;

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct packed {
      logic [7:0] a;
      logic [7:0] d;
   } wr_t;

   wr_t        wr_q[$];
   logic [7:0] rd_q[$];
   logic [7:0] model [0:255];

   always #5 clk = ~clk;

   spi_sram_responder #(
      .ADDR_W    (8),
      .CMD_READ  (8'h03),
      .CMD_WRITE (8'h02)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .sck     (sck),
      .cs_n    (cs_n),
      .mosi    (mosi),
      .miso    (miso),
      .active  (active),
      .wr_stb  (wr_stb),
      .wr_addr (wr_addr),
      .wr_data (wr_data)
   );

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Commit monitor: every strobe must match the oldest expected write.
   always @(negedge clk) begin
      if (!reset && wr_stb === 1'b1) begin
         if (wr_q.size() == 0) begin
            check("wr_unexpected", 16'(wr_q.size()), 16'd1);
         end else begin
            wr_t e;
            e = wr_q.pop_front();
            check("wr_commit", {wr_addr, wr_data}, {e.a, e.d});
            $display("write commit addr=%h data=%h", wr_addr, wr_data);
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic spi_bits(input int n, input logic [7:0] tx, output logic [7:0] rx);
      rx = '0;
      for (int i = 0; i < n; i++) begin
         mosi = tx[7-i];
         tick(HALF);
         rx[7-i] = miso;
         sck = 1'b1;
         tick(HALF);
         sck = 1'b0;
      end
   endtask

   task automatic cs_begin();
      cs_n = 1'b0;
      tick(HALF);
      check("active_rise", 16'(active), 16'd1);
   endtask

   task automatic cs_end();
      tick(HALF);
      cs_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("active_drop", 16'(active), 16'd0);
      tick(8);
   endtask

   task automatic send_hdr(input logic [7:0] cmd, input logic [23:0] a);
      logic [7:0] rx;
      spi_bits(8, cmd, rx);
      spi_bits(8, a[23:16], rx);
      spi_bits(8, a[15:8], rx);
      spi_bits(8, a[7:0], rx);
   endtask

   task automatic spi_write(input logic [23:0] a, input int n, input logic [15:0] data);
      logic [7:0] rx;
      logic [7:0] b;
      logic [7:0] wa;
      cs_begin();
      send_hdr(8'h02, a);
      for (int k = 0; k < n; k++) begin
         b  = (k == 0) ? data[15:8] : data[7:0];
         wa = a[7:0] + 8'(k);
         wr_q.push_back('{a: wa, d: b});
         model[wa] = b;
         spi_bits(8, b, rx);
      end
      cs_end();
   endtask

   task automatic spi_read(input logic [23:0] a, input int n);
      logic [7:0] rx;
      logic [7:0] exp;
      cs_begin();
      send_hdr(8'h03, a);
      for (int k = 0; k < n; k++) begin
         rd_q.push_back(model[a[7:0] + 8'(k)]);
         spi_bits(8, 8'h00, rx);
         exp = rd_q.pop_front();
         check("read_byte", {8'h00, rx}, {8'h00, exp});
         $display("read addr=%h data=%h expected=%h", a[7:0] + 8'(k), rx, exp);
      end
      cs_end();
   endtask

   initial begin
      logic [7:0] rx;
      logic [7:0] seen;

      reset = 1'b1;
      sck   = 1'b0;
      cs_n  = 1'b1;
      mosi  = 1'b0;
      tick(3);
      check("rst_miso", 16'(miso), 16'd0);
      check("rst_active", 16'(active), 16'd0);
      check("rst_wr_stb", 16'(wr_stb), 16'd0);
      check("rst_wr_addr", 16'(wr_addr), 16'd0);
      check("rst_wr_data", 16'(wr_data), 16'd0);
      reset = 1'b0;
      tick(4);

      // Write then sequential read.
      spi_write(24'h000010, 2, 16'hA55A);
      spi_read(24'h000010, 2);

      // Address wrap across the top of the array.
      spi_write(24'h0000FF, 2, 16'h1122);
      spi_read(24'h000000, 1);
      spi_read(24'h0000FF, 2);

      // Upper address bits ignored.
      spi_write(24'hAB0003, 1, 16'h7700);
      spi_read(24'h000003, 1);

      // Aborted write: partial byte must never commit.
      spi_write(24'h000020, 1, 16'h3C00);
      cs_begin();
      send_hdr(8'h02, 24'h000020);
      spi_bits(5, 8'hFF, rx);
      cs_end();
      spi_read(24'h000020, 1);

      // Unknown opcode: miso stays low, no commit.
      cs_begin();
      spi_bits(8, 8'h9F, rx);
      seen = 8'h00;
      for (int k = 0; k < 4; k++) begin
         spi_bits(8, 8'hFF, rx);
         seen = seen | rx;
      end
      check("ignore_miso", {8'h00, seen}, 16'h0000);
      cs_end();
      spi_read(24'h000010, 1);

      // Chip-select glitch with no clocks.
      cs_n = 1'b0;
      tick(6);
      cs_n = 1'b1;
      tick(8);
      check("glitch_idle", 16'(active), 16'd0);

      // Reset in the middle of the second read byte.
      cs_begin();
      send_hdr(8'h03, 24'h000010);
      rd_q.push_back(model[8'h10]);
      spi_bits(8, 8'h00, rx);
      check("midrd_byte0", {8'h00, rx}, {8'h00, rd_q.pop_front()});
      spi_bits(4, 8'h00, rx);
      tick(2);
      check("midrd_miso_pre", 16'(miso), 16'd1);
      #3;
      reset = 1'b1;
      #1;
      check("midrd_rst_miso", 16'(miso), 16'd0);
      check("midrd_rst_active", 16'(active), 16'd0);
      cs_n = 1'b1;
      tick(4);
      reset = 1'b0;
      tick(4);
      spi_read(24'h000010, 2);

      check("wr_pending", 16'(wr_q.size()), 16'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
